if_fetch_unit: RTL

- Instruction fetch sequencer; the reader/consumer side of the PC register.
- Takes the current PC, issues instruction-memory reads over a valid/ready request channel, and accepts returned words.
- Presents each instruction with its PC to decode over a valid/ready channel.
- Drives the PC register's load enable and next value: sequential +4, or a redirect target from branch/jump resolution.

---
 rtl/if_fetch_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch sequencer.
// Reads the current PC, issues one instruction-memory read at a time,
// hands each returned word (with its PC) to decode, and drives the PC
// register's load enable / next value (sequential step or redirect).
module if_fetch_unit #(
  parameter logic [31:0] PC_STEP    = 32'd4,
  parameter int          ALIGN_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_ena,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_DRAIN = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_pend_pc;
  logic [31:0] r_inst_data;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;
  logic        r_fault;

  logic        w_misaligned;
  logic        w_req_valid;
  logic        w_pc_ena;
  logic [31:0] w_pc_next;

  // Any set bit among the low ALIGN_BITS of the PC makes it unfetchable.
  assign w_misaligned = |pc_in[ALIGN_BITS-1:0];

  // Request and PC-update strobes; redirect wins over the sequential step.
  always_comb begin
    w_req_valid = 1'b0;
    w_pc_ena    = 1'b0;
    w_pc_next   = 32'd0;
    if (rst) begin
      w_req_valid = 1'b0;
      w_pc_ena    = 1'b0;
      w_pc_next   = 32'd0;
    end else begin
      if ((r_state == S_REQ) && !w_misaligned) begin
        w_req_valid = 1'b1;
      end else begin
        w_req_valid = 1'b0;
      end
      if (redirect_valid) begin
        w_pc_ena  = 1'b1;
        w_pc_next = redirect_pc;
      end else if ((r_state == S_WAIT) && imem_resp_valid) begin
        w_pc_ena  = 1'b1;
        w_pc_next = r_pend_pc + PC_STEP;
      end else begin
        w_pc_ena  = 1'b0;
        w_pc_next = 32'd0;
      end
    end
  end

  // Fetch state machine with the registered decode-side outputs and fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pend_pc    <= 32'd0;
      r_inst_data  <= 32'd0;
      r_inst_pc    <= 32'd0;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else if (redirect_valid) begin
      // A redirect drops any presented instruction and clears a fault;
      // only an already-accepted request leaves a response to drain.
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
      case (r_state)
        S_REQ: begin
          if (imem_req_ready && !w_misaligned) begin
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_WAIT, S_DRAIN: begin
          if (imem_resp_valid) begin
            r_state <= S_REQ;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (w_misaligned) begin
            r_fault <= 1'b1;
            r_state <= S_FAULT;
          end else if (imem_req_ready) begin
            r_pend_pc <= pc_in;
            r_state   <= S_WAIT;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            r_inst_data  <= imem_resp_data;
            r_inst_pc    <= r_pend_pc;
            r_inst_valid <= 1'b1;
            r_state      <= S_OUT;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_OUT: begin
          if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_REQ;
          end else begin
            r_state <= S_OUT;
          end
        end
        S_DRAIN: begin
          if (imem_resp_valid) begin
            r_state <= S_REQ;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = pc_in;
  assign pc_ena         = w_pc_ena;
  assign pc_next        = w_pc_next;
  assign inst_valid     = r_inst_valid;
  assign inst_data      = r_inst_data;
  assign inst_pc        = r_inst_pc;
  assign fetch_fault    = r_fault;

endmodule
